micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Microprogram next-state controller for the ARM control unit.
- Each cycle it selects the next microstore address from one of these sources:
  - the instruction encoder's 7-bit start state (dispatch),
  - a fixed fetch state,
  - the incremented current state,
  - a microinstruction jump field,
  - a single-level return register.
- It also sequences memory waits against the MOC handshake, with a timeout.
- It sits between the instruction encoder, the condition tester, memory, and the control-store ROM, whose address is this block's state output.

Parameters:
SW, 7, state/address width (matches encoder output width)
RESET_STATE, 7'd0, state loaded on reset
FETCH_STATE, 7'd1, first microstate of instruction fetch
ABORT_STATE, 7'd127, state entered on memory wait timeout
TIMEOUT, 15, max cycles held in a wait before abort (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
encoder_in  input  SW  start state from instruction encoder
ns_sel  input  3  next-state select field of current microinstruction
cr_addr  input  SW  jump/call target field of current microinstruction
cond_sel  input  2  test select: 00 const 1, 01 cond_pass, 10 moc, 11 encoder_in==0
inv  input  1  invert selected test
cond_pass  input  1  ARM condition-code test result from condition tester
moc  input  1  memory operation complete
state  output  SW  current microstate (control-store address), registered
ret_addr  output  SW  return register contents
ret_valid  output  1  return register holds a live address
mem_timeout  output  1  one-cycle pulse when a wait aborts

Behaviour:
- Reset (async, any time, including mid-wait or mid-call):
  - state=RESET_STATE, ret_addr=0, ret_valid=0, mem_timeout=0, wait counter=0.
- Test definition: T = selected_test XOR inv, evaluated combinationally from the current cycle's inputs.
- Next state is registered on the rising clk edge (1-cycle latency). inc = state+1 modulo 2^SW, so 127 wraps to 0.
- ns_sel encoding:
  - 000 dispatch: state<=encoder_in. A zero encoder_in yields state 0.
  - 001 fetch: state<=FETCH_STATE.
  - 010 cond branch: state<= T ? cr_addr : inc.
  - 011 increment: state<=inc.
  - 100 call: ret_addr<=inc, ret_valid<=1, state<=cr_addr.
    - A call while ret_valid=1 overwrites ret_addr (single level, no stack).
  - 101 return:
    - If ret_valid: state<=ret_addr, ret_valid<=0.
    - Else state<=FETCH_STATE.
  - 110 wait:
    - If T: state<=inc, wait counter<=0.
    - Else if wait counter==TIMEOUT-1: state<=ABORT_STATE, mem_timeout<=1 for one cycle, wait counter<=0, ret_valid<=0.
    - Else hold state, wait counter+=1.
  - 111 jump: state<=cr_addr.
- Wait counter:
  - Counts only in consecutive 110 cycles.
  - Cleared whenever ns_sel!=110 or on T.
  - T true on the first wait cycle gives zero stall.
- mem_timeout is 0 in every cycle except the one following the abort edge.
- ret_addr holds its value until the next call or reset. A return does not clear ret_addr, only ret_valid.
- All inputs are sampled only at the clock edge; no combinational path from inputs to state.

Test Plan:
1. Reset mid-wait:
   - Stimulus: ns_sel=110, cond_sel=10, moc=0 for 5 cycles, then assert reset asynchronously.
   - Response: state=0, counter=0, mem_timeout=0 immediately, before the next clk edge.
2. Fetch/dispatch:
   - Stimulus: state 1 with ns_sel=011, then ns_sel=000 with encoder_in=7'b0101100.
   - Response: state 1→2→44.
   - Check: with encoder_in=0 and cond_sel=11, inv=0, ns_sel=010, cr_addr=1, state goes to 1.
3. MOC wait:
   - Stimulus: state 10, ns_sel=110, cond_sel=10, moc rises on the 4th cycle.
   - Response: state held at 10 for 3 cycles, then 11; mem_timeout never asserted.
4. Timeout:
   - Stimulus: TIMEOUT=15, moc stuck 0.
   - Response: state held 14 extra cycles, then 127 on the 15th edge; mem_timeout high exactly 1 cycle; ret_valid cleared.
5. Call/return:
   - Stimulus: state 20 with ns_sel=100, cr_addr=90; then ns_sel=101; then a second 101.
   - Response: state 90, ret_addr=21, ret_valid=1; then state 21, ret_valid=0; then state FETCH_STATE=1.
6. Wrap and inverted branch:
   - Stimulus: state 127 with ns_sel=011.
   - Response: state 0.
   - Stimulus: cond_sel=01, cond_pass=1, inv=1, ns_sel=010, cr_addr=50 at state 30.
   - Response: state 31, since T=0 and the branch is not taken.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram next-state controller: picks the next control-store address from
// dispatch, fetch, increment, jump/call targets or the single-level return register.
module micro_sequencer #(
  parameter int unsigned     SW          = 7,
  parameter logic [SW-1:0]   RESET_STATE = '0,
  parameter logic [SW-1:0]   FETCH_STATE = SW'(1),
  parameter logic [SW-1:0]   ABORT_STATE = SW'(127),
  parameter int unsigned     TIMEOUT     = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [SW-1:0] encoder_in,
  input  logic [2:0]    ns_sel,
  input  logic [SW-1:0] cr_addr,
  input  logic [1:0]    cond_sel,
  input  logic          inv,
  input  logic          cond_pass,
  input  logic          moc,
  output logic [SW-1:0] state,
  output logic [SW-1:0] ret_addr,
  output logic          ret_valid,
  output logic          mem_timeout
);

  typedef enum logic [2:0] {
    NS_DISPATCH = 3'b000,
    NS_FETCH    = 3'b001,
    NS_BRANCH   = 3'b010,
    NS_INC      = 3'b011,
    NS_CALL     = 3'b100,
    NS_RETURN   = 3'b101,
    NS_WAIT     = 3'b110,
    NS_JUMP     = 3'b111
  } ns_sel_e;

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] ret_addr_q, ret_addr_d;
  logic          ret_valid_q, ret_valid_d;
  logic          mem_timeout_q, mem_timeout_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic          test_raw;
  logic          test_t;
  logic [SW-1:0] inc_state;
  ns_sel_e       ns_e;

  assign ns_e      = ns_sel_e'(ns_sel);
  assign inc_state = state_q + 1'b1;

  always_comb begin
    test_raw = 1'b1;
    case (cond_sel)
      2'b00:   test_raw = 1'b1;
      2'b01:   test_raw = cond_pass;
      2'b10:   test_raw = moc;
      default: test_raw = (encoder_in == '0);
    endcase
    test_t = test_raw ^ inv;
  end

  always_comb begin
    state_d       = state_q;
    ret_addr_d    = ret_addr_q;
    ret_valid_d   = ret_valid_q;
    mem_timeout_d = 1'b0;
    wait_cnt_d    = '0;
    case (ns_e)
      NS_DISPATCH: state_d = encoder_in;
      NS_FETCH:    state_d = FETCH_STATE;
      NS_BRANCH:   state_d = test_t ? cr_addr : inc_state;
      NS_INC:      state_d = inc_state;
      NS_CALL: begin
        ret_addr_d  = inc_state;
        ret_valid_d = 1'b1;
        state_d     = cr_addr;
      end
      NS_RETURN: begin
        if (ret_valid_q) begin
          state_d     = ret_addr_q;
          ret_valid_d = 1'b0;
        end else begin
          state_d = FETCH_STATE;
        end
      end
      NS_WAIT: begin
        // Counter only survives across back-to-back wait cycles; any other select clears it.
        if (test_t) begin
          state_d = inc_state;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = ABORT_STATE;
          mem_timeout_d = 1'b1;
          ret_valid_d   = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      NS_JUMP:     state_d = cr_addr;
      default:     state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RESET_STATE;
      ret_addr_q    <= '0;
      ret_valid_q   <= 1'b0;
      mem_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ret_addr_q    <= ret_addr_d;
      ret_valid_q   <= ret_valid_d;
      mem_timeout_q <= mem_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign state       = state_q;
  assign ret_addr    = ret_addr_q;
  assign ret_valid   = ret_valid_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: one task per scenario, hand-computed expectations.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] encoder_in;
  logic [2:0] ns_sel;
  logic [6:0] cr_addr;
  logic [1:0] cond_sel;
  logic       inv;
  logic       cond_pass;
  logic       moc;
  logic [6:0] state;
  logic [6:0] ret_addr;
  logic       ret_valid;
  logic       mem_timeout;

  int checks = 0;
  int errors = 0;

  micro_sequencer #(
    .SW(7),
    .RESET_STATE(7'd0),
    .FETCH_STATE(7'd1),
    .ABORT_STATE(7'd127),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .encoder_in(encoder_in),
    .ns_sel(ns_sel),
    .cr_addr(cr_addr),
    .cond_sel(cond_sel),
    .inv(inv),
    .cond_pass(cond_pass),
    .moc(moc),
    .state(state),
    .ret_addr(ret_addr),
    .ret_valid(ret_valid),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog state=%0d expected run to finish", state);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_state(input logic [6:0] s);
    ns_sel = 3'b111; cr_addr = s;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (state !== 7'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (ret_addr !== 7'd0) begin errors++; $display("FAIL reset_ret_addr got=%0d exp=0", ret_addr); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL reset_ret_valid got=%b exp=0", ret_valid); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    reset = 1'b0;
    tick();
    checks++; if (state !== 7'd0) begin errors++; $display("FAIL dispatch_zero_after_reset got=%0d exp=0", state); end
  endtask

  task automatic test_reset_mid_wait();
    ns_sel = 3'b100; cr_addr = 7'd5;
    tick();
    checks++; if (ret_valid !== 1'b1 || ret_addr !== 7'd1) begin errors++; $display("FAIL rmw_call got=%b/%0d exp=1/1", ret_valid, ret_addr); end
    ns_sel = 3'b110; cond_sel = 2'b10; inv = 1'b0; moc = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (state !== 7'd5) begin errors++; $display("FAIL rmw_hold got=%0d exp=5", state); end
    #2 reset = 1'b1;
    #1;
    checks++; if (state !== 7'd0) begin errors++; $display("FAIL rmw_async_state got=%0d exp=0", state); end
    checks++; if (ret_valid !== 1'b0 || ret_addr !== 7'd0) begin errors++; $display("FAIL rmw_async_ret got=%b/%0d exp=0/0", ret_valid, ret_addr); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rmw_async_timeout got=%b exp=0", mem_timeout); end
    reset = 1'b0;
    // A cleared counter needs the full 14 holds before aborting.
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++; if (state !== 7'd0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL rmw_counter_cleared cyc=%0d got=%0d/%b exp=0/0", i, state, mem_timeout); end
    end
    goto_state(7'd0);
  endtask

  task automatic test_fetch_dispatch();
    goto_state(7'd1);
    ns_sel = 3'b011;
    tick();
    checks++; if (state !== 7'd2) begin errors++; $display("FAIL inc got=%0d exp=2", state); end
    ns_sel = 3'b000; encoder_in = 7'b0101100;
    tick();
    checks++; if (state !== 7'd44) begin errors++; $display("FAIL dispatch got=%0d exp=44", state); end
    ns_sel = 3'b001;
    tick();
    checks++; if (state !== 7'd1) begin errors++; $display("FAIL fetch got=%0d exp=1", state); end
    goto_state(7'd44);
    encoder_in = 7'd0; cond_sel = 2'b11; inv = 1'b0; ns_sel = 3'b010; cr_addr = 7'd1;
    tick();
    checks++; if (state !== 7'd1) begin errors++; $display("FAIL branch_enc_zero got=%0d exp=1", state); end
    encoder_in = 7'd9; cr_addr = 7'd70;
    tick();
    checks++; if (state !== 7'd2) begin errors++; $display("FAIL branch_enc_nonzero got=%0d exp=2", state); end
    ns_sel = 3'b000; encoder_in = 7'd0;
    tick();
    checks++; if (state !== 7'd0) begin errors++; $display("FAIL dispatch_zero got=%0d exp=0", state); end
  endtask

  task automatic test_moc_wait();
    goto_state(7'd10);
    ns_sel = 3'b110; cond_sel = 2'b10; inv = 1'b0; moc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (state !== 7'd10 || mem_timeout !== 1'b0) begin errors++; $display("FAIL moc_hold cyc=%0d got=%0d/%b exp=10/0", i, state, mem_timeout); end
    end
    moc = 1'b1;
    tick();
    checks++; if (state !== 7'd11 || mem_timeout !== 1'b0) begin errors++; $display("FAIL moc_release got=%0d/%b exp=11/0", state, mem_timeout); end
    moc = 1'b0; cond_sel = 2'b00;
    tick();
    checks++; if (state !== 7'd12) begin errors++; $display("FAIL wait_zero_stall got=%0d exp=12", state); end
  endtask

  task automatic test_timeout();
    goto_state(7'd20);
    ns_sel = 3'b100; cr_addr = 7'd40;
    tick();
    checks++; if (state !== 7'd40 || ret_valid !== 1'b1 || ret_addr !== 7'd21) begin errors++; $display("FAIL to_call got=%0d/%b/%0d exp=40/1/21", state, ret_valid, ret_addr); end
    ns_sel = 3'b110; cond_sel = 2'b10; inv = 1'b0; moc = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++; if (state !== 7'd40 || mem_timeout !== 1'b0) begin errors++; $display("FAIL to_hold cyc=%0d got=%0d/%b exp=40/0", i, state, mem_timeout); end
    end
    tick();
    checks++; if (state !== 7'd127) begin errors++; $display("FAIL to_abort_state got=%0d exp=127", state); end
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", mem_timeout); end
    checks++; if (ret_valid !== 1'b0 || ret_addr !== 7'd21) begin errors++; $display("FAIL to_ret got=%b/%0d exp=0/21", ret_valid, ret_addr); end
    ns_sel = 3'b011;
    tick();
    checks++; if (mem_timeout !== 1'b0 || state !== 7'd0) begin errors++; $display("FAIL to_pulse_end got=%b/%0d exp=0/0", mem_timeout, state); end
  endtask

  task automatic test_call_return();
    goto_state(7'd20);
    ns_sel = 3'b100; cr_addr = 7'd90;
    tick();
    checks++; if (state !== 7'd90 || ret_addr !== 7'd21 || ret_valid !== 1'b1) begin errors++; $display("FAIL call got=%0d/%0d/%b exp=90/21/1", state, ret_addr, ret_valid); end
    ns_sel = 3'b101;
    tick();
    checks++; if (state !== 7'd21 || ret_valid !== 1'b0 || ret_addr !== 7'd21) begin errors++; $display("FAIL return got=%0d/%b/%0d exp=21/0/21", state, ret_valid, ret_addr); end
    tick();
    checks++; if (state !== 7'd1) begin errors++; $display("FAIL return_empty got=%0d exp=1", state); end
    goto_state(7'd5);
    ns_sel = 3'b100; cr_addr = 7'd60;
    tick();
    cr_addr = 7'd70;
    tick();
    checks++; if (state !== 7'd70 || ret_addr !== 7'd61) begin errors++; $display("FAIL call_overwrite got=%0d/%0d exp=70/61", state, ret_addr); end
    ns_sel = 3'b101;
    tick();
    checks++; if (state !== 7'd61) begin errors++; $display("FAIL return_overwrite got=%0d exp=61", state); end
  endtask

  task automatic test_wrap_branch();
    goto_state(7'd127);
    ns_sel = 3'b011;
    tick();
    checks++; if (state !== 7'd0) begin errors++; $display("FAIL wrap got=%0d exp=0", state); end
    goto_state(7'd30);
    cond_sel = 2'b01; cond_pass = 1'b1; inv = 1'b1; ns_sel = 3'b010; cr_addr = 7'd50;
    tick();
    checks++; if (state !== 7'd31) begin errors++; $display("FAIL branch_inv_not_taken got=%0d exp=31", state); end
    inv = 1'b0;
    tick();
    checks++; if (state !== 7'd50) begin errors++; $display("FAIL branch_taken got=%0d exp=50", state); end
    cond_pass = 1'b0; inv = 1'b1; cr_addr = 7'd100;
    tick();
    checks++; if (state !== 7'd100) begin errors++; $display("FAIL branch_inv_taken got=%0d exp=100", state); end
  endtask

  initial begin
    reset = 1'b1; encoder_in = '0; ns_sel = '0; cr_addr = '0;
    cond_sel = '0; inv = 1'b0; cond_pass = 1'b0; moc = 1'b0;
    test_reset();
    test_reset_mid_wait();
    test_fetch_dispatch();
    test_moc_wait();
    test_timeout();
    test_call_return();
    test_wrap_branch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
